// File: rtl/icache_miss_responder.sv
// Memory-side responder for icache line misses: moves one 16-byte line as four
// 32-bit beats on a single-outstanding word bus and returns a one-cycle response.
//
// state | meaning
// IDLE  | ready for a miss request
// BEAT  | word beat in flight on the bus
// RESP  | one-cycle response pulse
module icache_miss_responder #(
  parameter int MEM_LINES = 65536,
  parameter int TIMEOUT   = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [148:0] req_info,
  output logic         req_drop,
  output logic         rsp_valid,
  output logic [127:0] rsp_data,
  output logic         rsp_bus_error,
  output logic         bus_cyc,
  output logic         bus_we,
  output logic [23:0]  bus_addr,
  output logic [31:0]  bus_wdata,
  input  logic [31:0]  bus_rdata,
  input  logic         bus_ack,
  input  logic         bus_err
);

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  localparam logic [31:0] MEM_LINES_U = 32'(MEM_LINES);
  localparam logic [7:0]  TMO_LAST    = 8'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [19:0]   line_q;
  logic          we_q;
  logic [127:0]  line_data;
  logic [1:0]    beat_q;
  logic [7:0]    tmo_q;
  logic          in_range;
  logic          tmo_last;

  assign in_range = ({12'd0, req_info[148:129]} < MEM_LINES_U);
  assign tmo_last = (tmo_q == TMO_LAST);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = in_range ? BEAT : RESP;
      BEAT: begin
        if (bus_err)                        state_nxt = RESP;
        else if (bus_ack && beat_q == 2'd3) state_nxt = RESP;
        else if (!bus_ack && tmo_last)      state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    bus_cyc   = (state == BEAT);
    bus_we    = bus_cyc & we_q;
    bus_addr  = bus_cyc ? {line_q, beat_q, 2'b00} : 24'd0;
    bus_wdata = bus_cyc ? line_data[{beat_q, 5'b0} +: 32] : 32'd0;
  end

  // Read words land in the same buffer that carried the write data; the
  // response register is loaded on the transition into RESP so it lines up
  // with the rsp_valid pulse and then holds.
  always_ff @(posedge clock) begin
    if (reset) begin
      line_q        <= '0;
      we_q          <= 1'b0;
      line_data     <= '0;
      beat_q        <= '0;
      tmo_q         <= '0;
      req_drop      <= 1'b0;
      rsp_data      <= '0;
      rsp_bus_error <= 1'b0;
    end else begin
      if (req_valid && state != IDLE) req_drop <= 1'b1;
      case (state)
        IDLE: begin
          if (req_valid) begin
            line_q    <= req_info[148:129];
            we_q      <= req_info[128];
            line_data <= req_info[127:0];
            beat_q    <= '0;
            tmo_q     <= '0;
            if (!in_range) begin
              rsp_data      <= '0;
              rsp_bus_error <= 1'b1;
            end
          end
        end
        BEAT: begin
          if (bus_err) begin
            rsp_data      <= '0;
            rsp_bus_error <= 1'b1;
          end else if (bus_ack) begin
            if (!we_q) line_data[{beat_q, 5'b0} +: 32] <= bus_rdata;
            tmo_q  <= '0;
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              rsp_data      <= we_q ? 128'd0 : {bus_rdata, line_data[95:0]};
              rsp_bus_error <= 1'b0;
            end
          end else if (tmo_last) begin
            rsp_data      <= '0;
            rsp_bus_error <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_miss_responder.sv
// Scoreboard bench for icache_miss_responder: a default instance with a simple
// bus slave, plus a small instance (MEM_LINES=16, TIMEOUT=4) with a silent bus.
module tb_icache_miss_responder;

  typedef struct {
    int           cyc;
    logic [127:0] data;
    logic         err;
  } rsp_t;

  typedef struct {
    logic [23:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic         a_req_valid = 1'b0, a_req_ready, a_req_drop, a_rsp_valid, a_rsp_bus_error;
  logic [148:0] a_req_info = '0;
  logic [127:0] a_rsp_data;
  logic         a_bus_cyc, a_bus_we, a_bus_ack = 1'b0, a_bus_err = 1'b0;
  logic [23:0]  a_bus_addr;
  logic [31:0]  a_bus_wdata, a_bus_rdata = '0;

  logic         b_req_valid = 1'b0, b_req_ready, b_req_drop, b_rsp_valid, b_rsp_bus_error;
  logic [148:0] b_req_info = '0;
  logic [127:0] b_rsp_data;
  logic         b_bus_cyc, b_bus_we, b_bus_ack = 1'b0, b_bus_err = 1'b0;
  logic [23:0]  b_bus_addr;
  logic [31:0]  b_bus_wdata, b_bus_rdata = '0;

  icache_miss_responder dut_a (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_info(a_req_info),
    .req_drop(a_req_drop), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .rsp_bus_error(a_rsp_bus_error), .bus_cyc(a_bus_cyc), .bus_we(a_bus_we),
    .bus_addr(a_bus_addr), .bus_wdata(a_bus_wdata), .bus_rdata(a_bus_rdata),
    .bus_ack(a_bus_ack), .bus_err(a_bus_err)
  );

  icache_miss_responder #(.MEM_LINES(16), .TIMEOUT(4)) dut_b (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_info(b_req_info),
    .req_drop(b_req_drop), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .rsp_bus_error(b_rsp_bus_error), .bus_cyc(b_bus_cyc), .bus_we(b_bus_we),
    .bus_addr(b_bus_addr), .bus_wdata(b_bus_wdata), .bus_rdata(b_bus_rdata),
    .bus_ack(b_bus_ack), .bus_err(b_bus_err)
  );

  int errors = 0;
  int checks = 0;
  int ncyc = 0;
  int b_cyc_cnt = 0;
  int a_wcnt = 0;
  int wait_n = 0;
  int err_beat = 4;
  logic [31:0] rd_words [4];
  rsp_t  qa[$];
  rsp_t  qb[$];
  beat_t ba[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitors, cycle counter and the bus slave for dut_a share one
  // process so their ordering within a cycle is fixed.
  always @(negedge clock) begin
    rsp_t  r;
    beat_t b;
    ncyc++;
    if (b_bus_cyc) b_cyc_cnt++;
    if (a_rsp_valid) begin
      if (qa.size() == 0) chk("a_unexpected_rsp", a_rsp_valid, 1'b0);
      else begin
        r = qa.pop_front();
        chk("a_rsp_cycle", ncyc, r.cyc);
        chk("a_rsp_data", a_rsp_data, r.data);
        chk("a_rsp_err", a_rsp_bus_error, r.err);
      end
    end
    if (b_rsp_valid) begin
      if (qb.size() == 0) chk("b_unexpected_rsp", b_rsp_valid, 1'b0);
      else begin
        r = qb.pop_front();
        chk("b_rsp_cycle", ncyc, r.cyc);
        chk("b_rsp_data", b_rsp_data, r.data);
        chk("b_rsp_err", b_rsp_bus_error, r.err);
      end
    end
    if (a_bus_cyc) begin
      if (a_wcnt == wait_n) begin
        if (ba.size() == 0) chk("a_extra_beat", a_bus_cyc, 1'b0);
        else begin
          b = ba.pop_front();
          chk("a_beat_addr", a_bus_addr, b.addr);
          chk("a_beat_we", a_bus_we, b.we);
          if (b.we) chk("a_beat_wdata", a_bus_wdata, b.wdata);
        end
        a_bus_ack   = 1'b1;
        a_bus_err   = (int'(a_bus_addr[3:2]) == err_beat);
        a_bus_rdata = rd_words[a_bus_addr[3:2]];
        a_wcnt      = 0;
      end else begin
        a_bus_ack = 1'b0;
        a_bus_err = 1'b0;
        a_wcnt++;
      end
    end else begin
      a_bus_ack = 1'b0;
      a_bus_err = 1'b0;
      a_wcnt    = 0;
    end
  end

  // Called just after a rising edge; cycle 0 is the cycle req_valid is held.
  // lat < 0 means no response is expected.
  task automatic req_a(input logic [19:0] line, input logic we, input logic [127:0] data,
                       input int nbeats, input int lat, input logic [127:0] edata, input logic eerr);
    beat_t b;
    rsp_t  r;
    logic [1:0] k2;
    for (int k = 0; k < nbeats; k++) begin
      k2 = k[1:0];
      b.addr  = {line, k2, 2'b00};
      b.we    = we;
      b.wdata = data[32*k +: 32];
      ba.push_back(b);
    end
    if (lat >= 0) begin
      r.cyc = ncyc + 1 + lat; r.data = edata; r.err = eerr;
      qa.push_back(r);
    end
    a_req_info  = {line, we, data};
    a_req_valid = 1'b1;
    @(posedge clock); #1;
    a_req_valid = 1'b0;
  endtask

  task automatic req_b(input logic [19:0] line, input int lat, input logic [127:0] edata, input logic eerr);
    rsp_t r;
    r.cyc = ncyc + 1 + lat; r.data = edata; r.err = eerr;
    qb.push_back(r);
    b_req_info  = {line, 1'b0, 128'd0};
    b_req_valid = 1'b1;
    @(posedge clock); #1;
    b_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && (qa.size() > 0 || qb.size() > 0); i++) @(posedge clock);
    @(posedge clock); #1;
    chk("rsp_pending", qa.size() + qb.size(), 0);
    chk("beats_pending", ba.size(), 0);
    qa.delete(); qb.delete(); ba.delete();
  endtask

  initial begin
    rd_words[0] = 32'h0; rd_words[1] = 32'h0; rd_words[2] = 32'h0; rd_words[3] = 32'h0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("a_reset_ctrl", {a_req_ready, a_rsp_valid, a_bus_cyc, a_req_drop, a_rsp_bus_error}, 5'b10000);
    chk("a_reset_data", a_rsp_data, 128'd0);
    chk("a_reset_addr", a_bus_addr, 24'd0);
    chk("b_reset_ctrl", {b_req_ready, b_rsp_valid, b_bus_cyc, b_req_drop, b_rsp_bus_error}, 5'b10000);

    // zero-wait read
    rd_words[0] = 32'h11111111; rd_words[1] = 32'h22222222;
    rd_words[2] = 32'h33333333; rd_words[3] = 32'h44444444;
    wait_n = 0; err_beat = 4;
    req_a(20'h00012, 1'b0, 128'd0, 4, 5, 128'h44444444_33333333_22222222_11111111, 1'b0);
    wait_idle();

    // write with two wait cycles per beat
    wait_n = 2;
    req_a(20'h00003, 1'b1, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 4, 13, 128'd0, 1'b0);
    wait_idle();

    // bus_err together with bus_ack on beat 2
    wait_n = 0; err_beat = 2;
    req_a(20'h00020, 1'b0, 128'd0, 3, 4, 128'd0, 1'b1);
    wait_idle();
    err_beat = 4;

    // out-of-range on the default instance, and the last valid line
    req_a(20'h10000, 1'b0, 128'd0, 0, 1, 128'd0, 1'b1);
    wait_idle();
    rd_words[0] = 32'h05050505; rd_words[1] = 32'h06060606;
    rd_words[2] = 32'h07070707; rd_words[3] = 32'h08080808;
    req_a(20'h0FFFF, 1'b0, 128'd0, 4, 5, 128'h08080808_07070707_06060606_05050505, 1'b0);
    wait_idle();

    // reset during beat 1: no response, back to idle
    req_a(20'h00007, 1'b0, 128'd0, 2, -1, 128'd0, 1'b0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("a_reset_mid_cyc", a_bus_cyc, 1'b0);
    chk("a_reset_mid_ready", a_req_ready, 1'b1);
    repeat (8) @(posedge clock);
    #1;
    chk("a_reset_mid_beats", ba.size(), 0);
    ba.delete();
    rd_words[0] = 32'h9A000001; rd_words[1] = 32'h9A000002;
    rd_words[2] = 32'h9A000003; rd_words[3] = 32'h9A000004;
    req_a(20'h00001, 1'b0, 128'd0, 4, 5, 128'h9A000004_9A000003_9A000002_9A000001, 1'b0);
    wait_idle();

    // small instance: out-of-range line 0x10 never touches the bus
    b_cyc_cnt = 0;
    req_b(20'h00010, 1, 128'd0, 1'b1);
    wait_idle();
    chk("b_oor_no_cyc", b_cyc_cnt, 0);
    chk("b_drop_clear", b_req_drop, 1'b0);

    // small instance: silent bus times out after 4 cycles; busy request dropped
    b_cyc_cnt = 0;
    req_b(20'h00005, 5, 128'd0, 1'b1);
    @(posedge clock); #1;
    b_req_info  = {20'h00009, 1'b1, 128'hFFFF};
    b_req_valid = 1'b1;
    @(posedge clock); #1;
    b_req_valid = 1'b0;
    chk("b_drop_set", b_req_drop, 1'b1);
    chk("b_addr_kept", b_bus_addr, 24'h000050);
    wait_idle();
    chk("b_timeout_cycles", b_cyc_cnt, 4);
    chk("b_drop_sticky", b_req_drop, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
